keypad_encoder: RTL and testbench

Matrix-keypad front end for the doorlock: scans a 4-row × 3-column phone-layout keypad, synchronizes and debounces the row returns, and encodes each press into the entry signals the lock consumes. Digits produce `ps_num` plus a one-cycle strobe; `*` and `#` drive `ps_start` and `ps_end`. It runs on the undivided system clock, upstream of the lock's state machine and comparator.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/sync2.sv | 24 ++
 rtl/keypad_encoder.sv | 192 +++++++++++++++++++
 tb/tb_keypad_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad encoder: FSM states, special key codes,
// row one-hot detection and (row, column) to key-code decoding.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // True when exactly one of the active-low rows is pulled low.
  function automatic logic one_row_low(input logic [3:0] rs);
    logic [3:0] low;
    low = ~rs;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rs);
    logic [1:0] idx;
    case (~rs)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Phone layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic logic [3:0] key_decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    if (row_idx == 2'd3) begin
      case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the 4-bit asynchronous row returns; idles at all-ones (no key).
module sync2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// 4x3 keypad scanner/debouncer producing digit strobes and */# level outputs.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe held digits every REPEAT_CNT cycles.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 50000,
  parameter int unsigned REPEAT_CNT   = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_row,
  output logic [2:0] o_col,
  output logic [3:0] o_ps_num,
  output logic       o_key_strobe,
  output logic       o_ps_start,
  output logic       o_ps_end
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV + 1);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 1) begin : g_param_check
    $error("keypad_encoder: SCAN_DIV >= 4, DEBOUNCE_CNT >= 2, REPEAT_CNT >= 1 required");
  end

  state_e           r_state, w_state_d;
  logic [ScanW-1:0] r_scan_cnt, w_scan_cnt_d;
  logic [1:0]       r_col_idx, w_col_idx_d;
  logic [DbW-1:0]   r_db_cnt, w_db_cnt_d;
  logic [3:0]       r_row_code, w_row_code_d;
  logic [3:0]       r_ps_num, w_ps_num_d;
  logic             r_strobe, w_strobe_d;
  logic             r_start, w_start_d;
  logic             r_end, w_end_d;

  logic [3:0]       w_rs;
  logic [3:0]       w_key;
  logic [1:0]       w_col_next;
  logic             w_is_digit;
  logic             w_repeat_hit;

  sync2 u_sync2 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_row),
    .o_q   (w_rs)
  );

  assign w_key      = key_decode(row_index(r_row_code), r_col_idx);
  assign w_is_digit = (w_key != KEY_STAR) && (w_key != KEY_HASH);
  assign w_col_next = (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CNT + 1);

  logic [RepW-1:0] r_rep_cnt, w_rep_cnt_d;

  // Runs only while a digit stays held; anything else clears it.
  always_comb begin
    w_rep_cnt_d  = '0;
    w_repeat_hit = 1'b0;
    if (r_state == PRESSED && w_rs != 4'hF && w_is_digit) begin
      if (r_rep_cnt == RepW'(REPEAT_CNT - 1)) w_repeat_hit = 1'b1;
      else                                     w_rep_cnt_d  = r_rep_cnt + RepW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rep_cnt <= '0;
    else       r_rep_cnt <= w_rep_cnt_d;
  end
`else
  assign w_repeat_hit = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_scan_cnt_d = r_scan_cnt;
    w_col_idx_d  = r_col_idx;
    w_db_cnt_d   = r_db_cnt;
    w_row_code_d = r_row_code;
    w_ps_num_d   = r_ps_num;
    w_strobe_d   = 1'b0;
    w_start_d    = r_start;
    w_end_d      = r_end;

    unique case (r_state)
      SCAN: begin
        if (r_scan_cnt == ScanW'(SCAN_DIV - 1)) begin
          w_scan_cnt_d = '0;
          if (one_row_low(w_rs)) begin
            // The capture cycle counts as the first stable cycle.
            w_row_code_d = w_rs;
            w_db_cnt_d   = DbW'(1);
            w_state_d    = DEBOUNCE;
          end else begin
            w_col_idx_d = w_col_next;
          end
        end else begin
          w_scan_cnt_d = r_scan_cnt + ScanW'(1);
        end
      end

      DEBOUNCE: begin
        if (w_rs == r_row_code) begin
          if (r_db_cnt == DbW'(DEBOUNCE_CNT - 1)) begin
            w_db_cnt_d = '0;
            w_state_d  = PRESSED;
            if (w_key == KEY_STAR) begin
              w_start_d = 1'b1;
            end else if (w_key == KEY_HASH) begin
              w_end_d = 1'b1;
            end else begin
              w_ps_num_d = w_key;
              w_strobe_d = 1'b1;
            end
          end else begin
            w_db_cnt_d = r_db_cnt + DbW'(1);
          end
        end else begin
          w_db_cnt_d = '0;
          w_state_d  = SCAN;
        end
      end

      PRESSED: begin
        if (w_rs == 4'hF) begin
          w_db_cnt_d = DbW'(1);
          w_state_d  = RELEASE;
        end else if (w_repeat_hit) begin
          w_strobe_d = 1'b1;
        end
      end

      RELEASE: begin
        if (w_rs == 4'hF) begin
          if (r_db_cnt == DbW'(DEBOUNCE_CNT - 1)) begin
            w_db_cnt_d  = '0;
            w_start_d   = 1'b0;
            w_end_d     = 1'b0;
            w_col_idx_d = w_col_next;
            w_state_d   = SCAN;
          end else begin
            w_db_cnt_d = r_db_cnt + DbW'(1);
          end
        end else begin
          w_db_cnt_d = '0;
          w_state_d  = PRESSED;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= SCAN;
      r_scan_cnt <= '0;
      r_col_idx  <= 2'd0;
      r_db_cnt   <= '0;
      r_row_code <= 4'hF;
      r_ps_num   <= 4'h0;
      r_strobe   <= 1'b0;
      r_start    <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_scan_cnt <= w_scan_cnt_d;
      r_col_idx  <= w_col_idx_d;
      r_db_cnt   <= w_db_cnt_d;
      r_row_code <= w_row_code_d;
      r_ps_num   <= w_ps_num_d;
      r_strobe   <= w_strobe_d;
      r_start    <= w_start_d;
      r_end      <= w_end_d;
    end
  end

  always_comb begin
    case (r_col_idx)
      2'd0:    o_col = 3'b110;
      2'd1:    o_col = 3'b101;
      default: o_col = 3'b011;
    endcase
  end

  assign o_ps_num     = r_ps_num;
  assign o_key_strobe = r_strobe;
  assign o_ps_start   = r_start;
  assign o_ps_end     = r_end;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a keypad model drives rows from the column scan,
// expected output events are queued at stimulus time and matched as the DUT emits them.
module tb_keypad_encoder;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  ps_num;
  logic        key_strobe;
  logic        ps_start;
  logic        ps_end;

  logic [11:0] pressed;
  int          cyc;
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic [3:0] code;
    logic       fall;
    int         cyc;
    logic       at_least;
  } ev_t;

  ev_t sb[$];

  logic       prev_strobe = 1'b0;
  logic       prev_start  = 1'b0;
  logic       prev_end    = 1'b0;
  logic [3:0] prev_num    = 4'h0;

  keypad_encoder #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8),
    .REPEAT_CNT   (32)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_row        (row),
    .o_col        (col),
    .o_ps_num     (ps_num),
    .o_key_strobe (key_strobe),
    .o_ps_start   (ps_start),
    .o_ps_end     (ps_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key (r, c) is bit r*3+c; a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] code, input logic fall, input int at,
                           input logic at_least);
    ev_t e;
    e.code     = code;
    e.fall     = fall;
    e.cyc      = at;
    e.at_least = at_least;
    sb.push_back(e);
  endtask

  task automatic report_ev(input logic [3:0] code, input logic fall);
    ev_t e;
    check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq("ev_code", 32'(code), 32'(e.code));
      check_eq("ev_fall", 32'(fall), 32'(e.fall));
      if (e.at_least) check_eq("ev_min_cycle", 32'(cyc >= e.cyc), 1);
      else            check_eq("ev_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cyc != 0) begin
      if (key_strobe) begin
        check_eq("strobe_not_back2back", 32'(prev_strobe), 0);
        report_ev(ps_num, 1'b0);
      end
      if (ps_num != prev_num) check_eq("ps_num_with_strobe", 32'(key_strobe), 1);
      if (ps_start && !prev_start) report_ev(4'hA, 1'b0);
      if (!ps_start && prev_start) report_ev(4'hA, 1'b1);
      if (ps_end && !prev_end)     report_ev(4'hB, 1'b0);
      if (!ps_end && prev_end)     report_ev(4'hB, 1'b1);
    end
    prev_strobe <= key_strobe;
    prev_start  <= ps_start;
    prev_end    <= ps_end;
    prev_num    <= ps_num;
  end

  // Returns at the falling edge of cycle 0, the first cycle out of reset.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_col", 32'(col), 32'(3'b110));
    check_eq("rst_ps_num", 32'(ps_num), 0);
    check_eq("rst_outs", 32'({key_strobe, ps_start, ps_end}), 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] col_exp(input int k);
    case ((k / 4) % 3)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    pressed = '0;

    // 1: idle scan
    apply_reset(2);
    for (int k = 0; k < 12; k++) begin
      check_eq("t1_col", 32'(col), 32'(col_exp(k)));
      check_eq("t1_idle", 32'({key_strobe, ps_start, ps_end}), 0);
      @(negedge clk);
    end

    // 2: clean '5' (row1, col1): captured at cycle 7, strobe at 15
    pressed    = '0;
    pressed[4] = 1'b1;
    apply_reset(2);
    expect_ev(4'h5, 1'b0, 15, 1'b0);
    step(40);
    pressed = '0;
    step(25);
    check_eq("t2_ps_num", 32'(ps_num), 5);
    check_eq("t2_drained", sb.size(), 0);

    // 4: '#' (row3, col2): rise at 19, released at 30, fall at 40
    pressed     = '0;
    pressed[11] = 1'b1;
    apply_reset(2);
    expect_ev(4'hB, 1'b0, 19, 1'b0);
    expect_ev(4'hB, 1'b1, 40, 1'b0);
    step(30);
    pressed = '0;
    step(25);
    check_eq("t4_ps_num", 32'(ps_num), 0);
    check_eq("t4_drained", sb.size(), 0);

    // 3: bouncing '7' (row2, col0), solid from cycle 18 onward
    pressed    = '0;
    pressed[6] = 1'b1;
    apply_reset(2);
    expect_ev(4'h7, 1'b0, 21, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(3);
      pressed[6] = ~pressed[6];
    end
    pressed[6] = 1'b1;
    step(60);
    pressed = '0;
    step(30);
    check_eq("t3_ps_num", 32'(ps_num), 7);
    check_eq("t3_drained", sb.size(), 0);

    // 5: '1'+'4' together rejected, then '0' reset mid-debounce and re-debounced
    pressed    = '0;
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    apply_reset(2);
    step(24);
    pressed     = '0;
    pressed[10] = 1'b1;
    step(9);
    check_eq("t5_col_frozen", 32'(col), 32'(3'b101));
    step(2);
    apply_reset(1);
    expect_ev(4'h0, 1'b0, 15, 1'b0);
    step(30);
    pressed = '0;
    step(25);
    check_eq("t5_drained", sb.size(), 0);

    // 6: '9' (row2, col2) held 100 cycles past its strobe at 19
    pressed    = '0;
    pressed[8] = 1'b1;
    apply_reset(2);
    expect_ev(4'h9, 1'b0, 19, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
    expect_ev(4'h9, 1'b0, 51, 1'b0);
    expect_ev(4'h9, 1'b0, 83, 1'b0);
    expect_ev(4'h9, 1'b0, 115, 1'b0);
`endif
    step(60);
    check_eq("t6_col_frozen", 32'(col), 32'(3'b011));
    step(60);
    pressed = '0;
    step(25);
    check_eq("t6_ps_num", 32'(ps_num), 9);
    check_eq("t6_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
